mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency unified memory between the pipeline's IF stage
//  (instruction fetch) and MEM stage (load/store). Sequences each access with a req/ready

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_wait_timer.sv | 30 +++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        DM_ACC,
        RESP
    } arb_state_t;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/arb_wait_timer.sv
// Counts memory wait cycles of one access; only instantiated when ARB_TIMEOUT_EN is defined.
module arb_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    logic [CW-1:0] r_cnt;

    // Expiry fires on the MAX_WAIT-th waiting cycle, so the access aborts on that edge.
    assign o_expire = i_count && (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_count && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the IF and MEM pipeline stages.
// Define ARB_TIMEOUT_EN to abort accesses whose mem_ready never arrives within MAX_WAIT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_WAIT     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || MAX_WAIT < 1) begin : g_param_check
        $error("mem_port_arbiter: STARVE_LIMIT and MAX_WAIT must be at least 1");
    end

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [SW-1:0]     r_starve_cnt;
    logic              r_grant_dm;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [2:0]        r_mem_size;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_timeout;
    logic              w_in_acc;
    logic              w_is_idle;
    logic              w_starved;
    logic              w_grant_if;
    logic              w_grant_dm;
    logic              w_timeout;

    assign w_in_acc  = (r_state == IF_ACC) || (r_state == DM_ACC);
    assign w_is_idle = (r_state == IDLE);
    assign w_starved = (r_starve_cnt >= STARVE_MAX);

`ifdef ARB_TIMEOUT_EN
    arb_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_load   (w_is_idle),
        .i_count  (w_in_acc && !mem_ready),
        .o_expire (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Data wins ties unless a waiting fetch has already been overtaken STARVE_LIMIT times.
    always_comb begin
        w_next_state = r_state;
        w_grant_if   = 1'b0;
        w_grant_dm   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (dm_req && !(if_req && w_starved)) begin
                    w_next_state = DM_ACC;
                    w_grant_dm   = 1'b1;
                end else if (if_req) begin
                    w_next_state = IF_ACC;
                    w_grant_if   = 1'b1;
                end
            end
            IF_ACC, DM_ACC: begin
                if (mem_ready || w_timeout) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!if_req || w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dm && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Memory-side request is registered at grant and released on completion or abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_dm  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_timeout   <= 1'b0;
        end else if (w_grant_dm) begin
            r_grant_dm  <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_size  <= dm_funct3;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_timeout   <= 1'b0;
        end else if (w_grant_if) begin
            r_grant_dm  <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_size  <= FUNCT3_WORD;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_timeout   <= 1'b0;
        end else if (w_in_acc && (mem_ready || w_timeout)) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rdata   <= (mem_ready && !r_mem_we) ? mem_rdata : '0;
            r_timeout <= w_timeout;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_size  = r_mem_size;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign if_valid  = (r_state == RESP) && !r_grant_dm;
    assign dm_valid  = (r_state == RESP) && r_grant_dm;
    assign if_rdata  = r_rdata;
    assign dm_rdata  = r_rdata;
    assign err       = (r_state == RESP) && r_timeout;

    // Stalls are forced low while reset is held so the pipeline sees a quiet interface.
    assign stall_if  = if_req && !if_valid && !rst;
    assign stall_mem = dm_req && !dm_valid && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then randomized traffic against a
// transaction-level model. The timeout scenario is compiled in only when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (STARVE),
        .MAX_WAIT     (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_funct3 (dm_funct3),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for the next access to reach memory, checks it, holds off mem_ready for 'delay'
    // cycles and then completes it; returns on the negedge of the response cycle.
    task automatic applyStimulus(input string tag, input logic isDm, input logic [31:0] expAddr,
                                 input logic expWe, input int delay, input logic [31:0] data);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        checkOutput({tag, "Req"}, mem_req, 1);
        checkOutput({tag, "Addr"}, mem_addr, expAddr);
        checkOutput({tag, "We"}, mem_we, expWe);
        checkOutput({tag, "Size"}, mem_size, isDm ? dm_funct3 : 3'b010);
        if (expWe) checkOutput({tag, "Wdata"}, mem_wdata, dm_wdata);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checkOutput({tag, "HoldReq"}, mem_req, 1);
            checkOutput({tag, "HoldAddr"}, mem_addr, expAddr);
            checkOutput({tag, "HoldStall"}, isDm ? stall_mem : stall_if, 1);
        end
        mem_ready = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    // Random-phase model state: arbitration and latency expressed as cycle arithmetic.
    int          openAt;
    int          grantCyc;
    int          readyAt;
    int          validAt;
    int          overtakes;
    int          d;
    logic        accDm;
    logic        accWe;
    logic [2:0]  accSize;
    logic [31:0] accAddr;
    logic [31:0] accWdata;
    logic [31:0] respData;
    logic        expReq;
    logic        expIfV;
    logic        expDmV;

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_funct3 = '0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        repeat (2) @(negedge clk);
        checkOutput("rstMemReq", mem_req, 0);
        checkOutput("rstIfValid", if_valid, 0);
        checkOutput("rstDmValid", dm_valid, 0);
        checkOutput("rstStallIf", stall_if, 0);
        checkOutput("rstStallMem", stall_mem, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstAddr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single fetch");
        if_req = 1; if_addr = 32'h0000_0010;
        applyStimulus("fetch", 0, 32'h0000_0010, 0, 0, 32'h1234_5678);
        checkOutput("fetchValid", if_valid, 1);
        checkOutput("fetchData", if_rdata, 32'h1234_5678);
        checkOutput("fetchStall", stall_if, 0);
        checkOutput("fetchMemReqOff", mem_req, 0);
        if_req = 0;
        @(negedge clk);
        checkOutput("fetchValidOnce", if_valid, 0);

        $display("[TB] word store");
        dm_req = 1; dm_we = 1; dm_funct3 = 3'b010; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
        applyStimulus("store", 1, 32'h0000_0100, 1, 0, 32'hFFFF_FFFF);
        checkOutput("storeValid", dm_valid, 1);
        checkOutput("storeRdata", dm_rdata, 0);
        checkOutput("storeErr", err, 0);
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        checkOutput("storeValidOnce", dm_valid, 0);

        $display("[TB] slow load");
        dm_req = 1; dm_funct3 = 3'b100; dm_addr = 32'h0000_0200;
        applyStimulus("slowLoad", 1, 32'h0000_0200, 0, 5, 32'hCAFE_F00D);
        checkOutput("slowValid", dm_valid, 1);
        checkOutput("slowData", dm_rdata, 32'hCAFE_F00D);
        checkOutput("slowStallOff", stall_mem, 0);
        dm_req = 0;
        @(negedge clk);

        $display("[TB] simultaneous requests");
        if_req = 1; if_addr = 32'h0000_0040;
        dm_req = 1; dm_funct3 = 3'b010; dm_addr = 32'h0000_0300;
        applyStimulus("prioDm", 1, 32'h0000_0300, 0, 1, 32'hAAAA_0001);
        checkOutput("prioDmValid", dm_valid, 1);
        checkOutput("prioIfWaits", if_valid, 0);
        checkOutput("prioStallIf", stall_if, 1);
        dm_req = 0;
        applyStimulus("prioIf", 0, 32'h0000_0040, 0, 0, 32'hBBBB_0002);
        checkOutput("prioIfValid", if_valid, 1);
        checkOutput("prioIfData", if_rdata, 32'hBBBB_0002);
        if_req = 0;
        @(negedge clk);

        $display("[TB] fetch starvation");
        if_req = 1; if_addr = 32'h0000_0080;
        dm_req = 1; dm_addr = 32'h0000_0400;
        for (int i = 0; i < STARVE; i++) begin
            applyStimulus("starveDm", 1, 32'h0000_0400, 0, 0, 32'h0000_1000 + 32'(i));
            checkOutput("starveDmValid", dm_valid, 1);
        end
        applyStimulus("starveIf", 0, 32'h0000_0080, 0, 0, 32'h5555_AAAA);
        checkOutput("starveIfValid", if_valid, 1);
        checkOutput("starveIfData", if_rdata, 32'h5555_AAAA);
        if_req = 0; dm_req = 0;
        @(negedge clk);

        $display("[TB] reset during data access");
        if_req = 1; if_addr = 32'h0000_0044;
        dm_req = 1; dm_addr = 32'h0000_0500;
        @(negedge clk);
        checkOutput("midAccReq", mem_req, 1);
        checkOutput("midAccStall", stall_mem, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncMemReq", mem_req, 0);
        checkOutput("asyncStallMem", stall_mem, 0);
        checkOutput("asyncStallIf", stall_if, 0);
        if_req = 0; dm_req = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRstReq", mem_req, 0);
        checkOutput("postRstValid", dm_valid, 0);

`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            $display("[TB] memory timeout");
            if_req = 1; if_addr = 32'h0000_0600;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!mem_req && n < 20);
            checkOutput("toReq", mem_req, 1);
            n = 0;
            while (!if_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            checkOutput("toCycles", n, 15);
            checkOutput("toValid", if_valid, 1);
            checkOutput("toErr", err, 1);
            checkOutput("toData", if_rdata, 0);
            if_req = 0;
        end
`endif

        $display("[TB] randomized traffic");
        repeat (2) @(negedge clk);
        openAt = 0; grantCyc = -10; readyAt = -10; validAt = -10; overtakes = 0;
        accDm = 0; accWe = 0; accSize = '0; accAddr = '0; accWdata = '0; respData = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (cyc >= openAt && (if_req || dm_req)) begin
                accDm    = dm_req && !(if_req && overtakes >= STARVE);
                accAddr  = accDm ? dm_addr : if_addr;
                accWe    = accDm ? dm_we : 1'b0;
                accSize  = accDm ? dm_funct3 : 3'b010;
                accWdata = dm_wdata;
                d        = int'($urandom_range(0, 4));
                grantCyc = cyc;
                readyAt  = cyc + d;
                validAt  = cyc + d + 1;
                openAt   = cyc + d + 3;
                if (!accDm || !if_req) overtakes = 0;
                else if (overtakes < STARVE) overtakes++;
            end else if (!if_req) begin
                overtakes = 0;
            end
            expReq = (cyc >= grantCyc) && (cyc <= readyAt);
            expIfV = (cyc == validAt) && !accDm;
            expDmV = (cyc == validAt) && accDm;
            checkOutput("rndMemReq", mem_req, expReq);
            checkOutput("rndIfValid", if_valid, expIfV);
            checkOutput("rndDmValid", dm_valid, expDmV);
            checkOutput("rndStallIf", stall_if, if_req && !expIfV);
            checkOutput("rndStallMem", stall_mem, dm_req && !expDmV);
            checkOutput("rndErr", err, 0);
            if (expReq) begin
                checkOutput("rndAddr", mem_addr, accAddr);
                checkOutput("rndWe", mem_we, accWe);
                checkOutput("rndSize", mem_size, accSize);
                if (accWe) checkOutput("rndWdata", mem_wdata, accWdata);
            end
            if (expIfV) checkOutput("rndIfData", if_rdata, respData);
            if (expDmV) checkOutput("rndDmData", dm_rdata, respData);

            if (cyc == readyAt) begin
                mem_ready = 1'b1;
                mem_rdata = $urandom;
                respData  = accWe ? 32'h0 : mem_rdata;
            end else begin
                mem_ready = !expReq && ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end

            if (expIfV || (!if_req && $urandom_range(0, 2) == 0)) begin
                if_req  = (expIfV && !if_req) ? 1'b0 : ($urandom_range(0, 1) == 1);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (expDmV || (!dm_req && $urandom_range(0, 2) == 0)) begin
                dm_req    = $urandom_range(0, 1) == 1;
                dm_we     = $urandom_range(0, 1) == 1;
                dm_funct3 = 3'($urandom_range(0, 5));
                dm_addr   = $urandom;
                dm_wdata  = $urandom;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
